// File: rtl/pll_clkdiv_bank.sv
// Lock qualification plus NUM_CH glitch-free, runtime-programmable clock dividers on refclk.
// Optional macro CLKDIV_PHASE_EN adds a per-channel programmable start phase (cfg_phase).
module pll_clkdiv_bank #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
`ifdef CLKDIV_PHASE_EN
  input  logic [DIV_W-1:0]  cfg_phase,
`endif
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] clk_en,
  output logic              locked,
  output logic              cfg_err
);

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0]   LCNT_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DEF_P     = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_H     = DIV_W'(DEFAULT_DIV / 2);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_COUNT     = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  logic           sync1_q, sync2_q, lk_s;
  state_t         state_q, state_d;
  logic [LCW-1:0] lcnt_q, lcnt_d;
  logic           locked_q, locked_d;
  logic           run_ok_s;
  logic           cfg_ok_s;
  logic           cfg_err_q;

`ifdef CLKDIV_PHASE_EN
  // Extra low cycles needed to move from phase old_ph to new_ph within a period of per cycles.
  function automatic logic [DIV_W-1:0] phase_delta(input logic [DIV_W-1:0] new_ph,
                                                   input logic [DIV_W-1:0] old_ph,
                                                   input logic [DIV_W-1:0] per);
    logic [DIV_W:0] old_m;
    logic [DIV_W:0] sum;
    old_m = {1'b0, old_ph % per};
    sum   = {1'b0, new_ph} + {1'b0, per} - old_m;
    return DIV_W'(sum % {1'b0, per});
  endfunction
`endif

  // Two-flop synchroniser for the asynchronous raw lock.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign lk_s = sync2_q;

  // Lock FSM state, stability counter and qualified-lock register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q  <= S_WAIT_LOCK;
      lcnt_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lcnt_q   <= lcnt_d;
      locked_q <= locked_d;
    end
  end

  // Lock FSM next state: lk_s must stay high for LOCK_CYCLES counted cycles.
  always_comb begin
    state_d = state_q;
    lcnt_d  = '0;
    case (state_q)
      S_WAIT_LOCK: begin
        if (lk_s) state_d = S_COUNT;
        else      state_d = S_WAIT_LOCK;
      end
      S_COUNT: begin
        if (!lk_s) begin
          state_d = S_WAIT_LOCK;
        end else if (lcnt_q == LCNT_LAST) begin
          state_d = S_RUN;
        end else begin
          state_d = S_COUNT;
          lcnt_d  = lcnt_q + LCW'(1);
        end
      end
      S_RUN: begin
        if (!lk_s) state_d = S_WAIT_LOCK;
        else       state_d = S_RUN;
      end
      default: state_d = S_WAIT_LOCK;
    endcase
  end

  // Lock FSM outputs; channels run only on edges where RUN is both current and kept.
  always_comb begin
    locked_d = (state_d == S_RUN);
    run_ok_s = (state_q == S_RUN) && lk_s;
  end

  // Configuration write legality.
  always_comb begin
    cfg_ok_s = ({1'b0, cfg_ch} < 5'(NUM_CH)) && (cfg_div >= DIV_W'(2)) &&
               (cfg_high != '0) && (cfg_high < cfg_div);
`ifdef CLKDIV_PHASE_EN
    cfg_ok_s = cfg_ok_s && (cfg_phase < cfg_div);
`endif
  end

  // Rejected-write pulse, one cycle after the strobe.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= cfg_wr && !cfg_ok_s;
  end

  assign locked  = locked_q;
  assign cfg_err = cfg_err_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DIV_W-1:0] sh_p_q, sh_p_d, sh_h_q, sh_h_d;
    logic [DIV_W-1:0] ac_p_q, ac_p_d, ac_h_q, ac_h_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             act_q, act_d;
    logic             oc_q, oc_d, ce_q, ce_d;
    logic             start_s;
    logic             wr_hit_s;
`ifdef CLKDIV_PHASE_EN
    logic [DIV_W-1:0] sh_ph_q, sh_ph_d, ac_ph_q, ac_ph_d, dly_q, dly_d;
`endif

    assign wr_hit_s = cfg_wr && cfg_ok_s && (cfg_ch == 4'(c));

    // Channel next state: shadow capture, period counting, and active update at wrap or idle.
    always_comb begin
      if (wr_hit_s) begin
        sh_p_d = cfg_div;
        sh_h_d = cfg_high;
      end else begin
        sh_p_d = sh_p_q;
        sh_h_d = sh_h_q;
      end
      ac_p_d  = ac_p_q;
      ac_h_d  = ac_h_q;
      cnt_d   = '0;
      act_d   = 1'b0;
      start_s = 1'b0;
`ifdef CLKDIV_PHASE_EN
      sh_ph_d = wr_hit_s ? cfg_phase : sh_ph_q;
      ac_ph_d = ac_ph_q;
      dly_d   = '0;
`endif
      if (!run_ok_s) begin
        ac_p_d = sh_p_q;
        ac_h_d = sh_h_q;
`ifdef CLKDIV_PHASE_EN
        ac_ph_d = sh_ph_q;
`endif
      end else if (!act_q) begin
        ac_p_d  = sh_p_q;
        ac_h_d  = sh_h_q;
        act_d   = ch_en[c];
        start_s = ch_en[c];
`ifdef CLKDIV_PHASE_EN
        ac_ph_d = sh_ph_q;
        dly_d   = ch_en[c] ? sh_ph_q : '0;
      end else if (dly_q != '0) begin
        // Leading low cycles of a phase offset; no pulse has been emitted yet.
        act_d   = ch_en[c];
        start_s = ch_en[c];
        dly_d   = ch_en[c] ? (dly_q - DIV_W'(1)) : '0;
`endif
      end else if (cnt_q == (ac_p_q - DIV_W'(1))) begin
        ac_p_d  = sh_p_q;
        ac_h_d  = sh_h_q;
        act_d   = ch_en[c];
        start_s = ch_en[c];
`ifdef CLKDIV_PHASE_EN
        ac_ph_d = sh_ph_q;
        dly_d   = ch_en[c] ? phase_delta(sh_ph_q, ac_ph_q, sh_p_q) : '0;
`endif
      end else begin
        act_d = 1'b1;
        cnt_d = cnt_q + DIV_W'(1);
      end
`ifdef CLKDIV_PHASE_EN
      oc_d = act_d && (dly_d == '0) && (cnt_d < ac_h_d);
      ce_d = start_s && (dly_d == '0);
`else
      oc_d = act_d && (cnt_d < ac_h_d);
      ce_d = start_s;
`endif
    end

    // Channel registers; outclk and clk_en come straight from flops.
    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        sh_p_q <= DEF_P;
        sh_h_q <= DEF_H;
        ac_p_q <= DEF_P;
        ac_h_q <= DEF_H;
        cnt_q  <= '0;
        act_q  <= 1'b0;
        oc_q   <= 1'b0;
        ce_q   <= 1'b0;
      end else begin
        sh_p_q <= sh_p_d;
        sh_h_q <= sh_h_d;
        ac_p_q <= ac_p_d;
        ac_h_q <= ac_h_d;
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        oc_q   <= oc_d;
        ce_q   <= ce_d;
      end
    end

`ifdef CLKDIV_PHASE_EN
    // Phase shadow, active phase and pending low-cycle delay.
    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        sh_ph_q <= '0;
        ac_ph_q <= '0;
        dly_q   <= '0;
      end else begin
        sh_ph_q <= sh_ph_d;
        ac_ph_q <= ac_ph_d;
        dly_q   <= dly_d;
      end
    end
`endif

    assign outclk[c] = oc_q;
    assign clk_en[c] = ce_q;
  end

endmodule

// File: tb/tb_pll_clkdiv_bank.sv
// Scoreboard bench for pll_clkdiv_bank: a time-based reference model predicts every cycle's outputs.
module tb_pll_clkdiv_bank;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int LC  = 16;
  localparam int DD  = 4;

  logic           refclk;
  logic           rst;
  logic           pll_locked;
  logic [NCH-1:0] ch_en;
  logic           cfg_wr;
  logic [3:0]     cfg_ch;
  logic [DW-1:0]  cfg_div;
  logic [DW-1:0]  cfg_high;
  logic [NCH-1:0] outclk;
  logic [NCH-1:0] clk_en;
  logic           locked;
  logic           cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  pll_clkdiv_bank #(.NUM_CH(NCH), .DIV_W(DW), .LOCK_CYCLES(LC), .DEFAULT_DIV(DD)) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .ch_en     (ch_en),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .outclk    (outclk),
    .clk_en    (clk_en),
    .locked    (locked),
    .cfg_err   (cfg_err)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  // ---------------- reference model ----------------
  // locked after edge n  <=> pll_locked sampled high on the LC+1 consecutive edges ending at n-2.
  // A channel period that starts at edge s shows high while (n-s) < H and ends at edge s+P.
  logic [2*NCH+1:0] exp_q[$];
  int  runq[$];
  int  n_edge;
  bit  lk_prev, lk_now, run_ok, wr_ok;
  int  run_now;
  bit  busy_m[NCH];
  int  start_m[NCH], ap_m[NCH], ah_m[NCH], sp_m[NCH], sh_m[NCH];
  logic [NCH-1:0] eo, ec;

  always @(posedge refclk) begin
    if (rst) begin
      runq.delete();
      lk_prev = 1'b0;
      n_edge  = 0;
      for (int c = 0; c < NCH; c++) begin
        busy_m[c] = 1'b0; start_m[c] = 0;
        ap_m[c] = DD; ah_m[c] = DD / 2; sp_m[c] = DD; sh_m[c] = DD / 2;
      end
      exp_q.push_back('0);
    end else begin
      n_edge++;
      if (pll_locked) run_now = (runq.size() > 0) ? runq[runq.size()-1] + 1 : 1;
      else            run_now = 0;
      runq.push_back(run_now);
      if (runq.size() > 3) void'(runq.pop_front());
      lk_now = (runq.size() == 3) && (runq[0] >= LC + 1);
      run_ok = lk_now && lk_prev;
      for (int c = 0; c < NCH; c++) begin
        if (!run_ok) begin
          busy_m[c] = 1'b0;
        end else if (!busy_m[c]) begin
          if (ch_en[c]) begin
            busy_m[c] = 1'b1; start_m[c] = n_edge; ap_m[c] = sp_m[c]; ah_m[c] = sh_m[c];
          end
        end else if (n_edge - start_m[c] == ap_m[c]) begin
          if (ch_en[c]) begin
            start_m[c] = n_edge; ap_m[c] = sp_m[c]; ah_m[c] = sh_m[c];
          end else begin
            busy_m[c] = 1'b0;
          end
        end
        eo[c] = busy_m[c] && ((n_edge - start_m[c]) < ah_m[c]);
        ec[c] = busy_m[c] && (n_edge == start_m[c]);
      end
      wr_ok = (int'(cfg_ch) < NCH) && (int'(cfg_div) >= 2) && (int'(cfg_high) >= 1) &&
              (int'(cfg_high) < int'(cfg_div));
      if (cfg_wr && wr_ok) begin
        sp_m[cfg_ch] = int'(cfg_div);
        sh_m[cfg_ch] = int'(cfg_high);
      end
      exp_q.push_back({lk_now, cfg_wr && !wr_ok, eo, ec});
      lk_prev = lk_now;
    end
  end

  // ---------------- monitor ----------------
  logic [2*NCH+1:0] got_v, exp_v;
  always @(negedge refclk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {locked, cfg_err, outclk, clk_en};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs @%0t: got locked=%b cfg_err=%b outclk=%b clk_en=%b, expected locked=%b cfg_err=%b outclk=%b clk_en=%b",
                 $time, got_v[2*NCH+1], got_v[2*NCH], got_v[2*NCH-1:NCH], got_v[NCH-1:0],
                 exp_v[2*NCH+1], exp_v[2*NCH], exp_v[2*NCH-1:NCH], exp_v[NCH-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic cfg_write(input int ch, input int dv, input int hi);
    cfg_wr   = 1'b1;
    cfg_ch   = 4'(ch);
    cfg_div  = 8'(dv);
    cfg_high = 8'(hi);
    tick(1);
    cfg_wr   = 1'b0;
  endtask

  // Raise pll_locked and count edges until locked appears; expect LC+2 edges after the first sample.
  task automatic lock_latency(input string name);
    int seen;
    seen = -1;
    pll_locked = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick(1);
      if (locked === 1'b1) begin
        seen = k - 1;
        break;
      end
    end
    n_tests++;
    if (seen != LC + 2) begin
      n_fail++;
      $display("FAIL %s: locked latency %0d edges, expected %0d (-1 = timeout)", name, seen, LC + 2);
    end
  endtask

  int drop_left;

  initial begin
    rst = 1'b1; pll_locked = 1'b0; ch_en = '1;
    cfg_wr = 1'b0; cfg_ch = 4'd0; cfg_div = 8'd0; cfg_high = 8'd0;
    tick(3);
    rst = 1'b0;
    tick(4);
    lock_latency("lock_qual");
    tick(12);
    // ch1 reconfiguration mid-period, then two stacked writes on ch0
    tick(1);
    cfg_write(1, 5, 1);
    tick(12);
    cfg_write(0, 6, 3);
    cfg_write(0, 7, 2);
    tick(20);
    // rejected writes
    cfg_write(0, 1, 0);
    cfg_write(0, 4, 0);
    cfg_write(0, 4, 4);
    cfg_write(7, 4, 2);
    tick(4);
    // enable / disable ch2
    ch_en[2] = 1'b0;
    tick(9);
    ch_en[2] = 1'b1;
    tick(9);
    // lock loss in RUN, then glitch during counting
    pll_locked = 1'b0;
    tick(6);
    pll_locked = 1'b1;
    tick(10);
    pll_locked = 1'b0;
    tick(3);
    lock_latency("lock_glitch");
    tick(8);
    // randomized traffic
    drop_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (drop_left > 0) begin
        drop_left--;
        pll_locked = (drop_left == 0);
      end else if ($urandom_range(0, 399) == 0) begin
        drop_left  = $urandom_range(1, 6);
        pll_locked = 1'b0;
      end else begin
        pll_locked = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) ch_en[$urandom_range(0, NCH - 1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        cfg_wr   = 1'b1;
        cfg_ch   = 4'($urandom_range(0, 5));
        cfg_div  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(1, 8));
        cfg_high = 8'($urandom_range(0, int'(cfg_div) + 1));
      end else begin
        cfg_wr = 1'b0;
      end
      tick(1);
    end
    cfg_wr = 1'b0;
    tick(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_clkdiv_bank.md
Name: pll_clkdiv_bank

Overview:
- Parametrised successor to the single-output PLL wrapper.
- Runs on the PLL output clock and qualifies the raw PLL lock with a synchroniser and a stability counter.
- Generates NUM_CH phase-aligned, runtime-programmable divided clocks, with one-cycle clock-enable strobes for downstream logic.
- Ratio and duty updates are glitch-free: they take effect only at period boundaries.

Parameters:
- NUM_CH, 4: number of divided-clock channels (1..16).
- DIV_W, 8: width of the divide and high-time fields.
- LOCK_CYCLES, 16: consecutive cycles of synchronised lock required before release (>=1).
- DEFAULT_DIV, 4: reset period of every channel, in refclk cycles (2..2^DIV_W-1).

Ports:
- refclk  in  1  sole clock (PLL output clock).
- rst  in  1  asynchronous active-high reset.
- pll_locked  in  1  raw lock from the PLL; asynchronous to refclk.
- ch_en  in  NUM_CH  per-channel run enable.
- cfg_wr  in  1  single-cycle configuration write strobe.
- cfg_ch  in  4  target channel index.
- cfg_div  in  DIV_W  period P in refclk cycles.
- cfg_high  in  DIV_W  high time H in refclk cycles.
- outclk  out  NUM_CH  registered divided clocks.
- clk_en  out  NUM_CH  one-cycle strobe at the start of each high phase.
- locked  out  1  qualified lock.
- cfg_err  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Reset (async assert, sync release): FSM=WAIT_LOCK, all counters 0; outclk=0, clk_en=0, locked=0, cfg_err=0; active and shadow P=DEFAULT_DIV, H=DEFAULT_DIV/2.
- Lock synchroniser: pll_locked passes through a 2-flop synchroniser to give lk_s.
- Lock FSM:
  - WAIT_LOCK: lock counter held at 0; lk_s=1 -> COUNT.
  - COUNT: counter increments; lk_s=0 -> WAIT_LOCK (counter cleared); counter==LOCK_CYCLES-1 with lk_s=1 -> RUN.
  - RUN: locked=1; lk_s=0 -> WAIT_LOCK, locked=0 on the same edge.
  - Net latency: locked rises LOCK_CYCLES+2 edges after pll_locked is first sampled high, with no glitches.
- Outside RUN: all channel counters are forced to 0; outclk and clk_en are forced to 0.
- Channel counter: cnt runs 0..P-1 and wraps.
  - outclk is high for cnt<H, low otherwise, registered.
  - clk_en is high in the first outclk-high cycle of each period.
- Start alignment: on RUN entry, every enabled channel starts at cnt=0 together. First outclk/clk_en high is the cycle after locked rises.
- Configuration write:
  - Accepted if cfg_ch<NUM_CH, 2<=cfg_div, and 1<=cfg_high<=cfg_div-1. Then shadow[cfg_ch] <= {cfg_div, cfg_high}.
  - Otherwise the shadow is unchanged and cfg_err pulses 1 cycle, 1 cycle after cfg_wr.
  - Shadow copies to active on the wrap edge (cnt==P-1 -> 0), or immediately if the channel is idle.
  - Multiple writes before a wrap: last accepted write wins.
  - Write in the same cycle as a wrap: applies at the following wrap.
- ch_en deassert: the channel completes its current period, then holds cnt=0 and outclk=0. No runt pulse.
- ch_en assert on an idle channel: cnt starts at 0 on the next cycle, so outclk goes high 1 cycle after ch_en.
- Lock loss mid-period: outclk is truncated to 0 immediately. This is the accepted exception: downstream logic is held in reset by locked=0.
- Active P/H are retained across lock loss; only a rst assertion restores defaults.

Optional Feature:
- Macro CLKDIV_PHASE_EN.
- When defined:
  - Adds input cfg_phase [DIV_W-1:0], written with the other cfg fields.
  - Accepted only if cfg_phase<cfg_div; otherwise cfg_err.
  - At RUN entry or ch_en assertion, the channel holds low for cfg_phase extra cycles before cnt starts. This gives a programmable phase offset between channels.
  - A phase change applied at a wrap inserts the delta (new-old mod P) as extra low cycles once.
- When undefined: the port is absent and the phase is always 0; all channels stay edge-aligned.

Test Plan:
- Lock qualification: rst released; pll_locked=1 -> locked rises exactly 18 cycles later (LOCK_CYCLES=16). ch0 outclk pattern is 2 high / 2 low with clk_en every 4th cycle.
- Lock glitch: pll_locked drops for 3 cycles at count 10 -> counter restarts; locked rises 18 cycles after the re-assert. Drop during RUN -> locked and all outclk reach 0 within 3 cycles of the drop.
- Glitch-free reconfiguration: ch1 write cfg_div=5, cfg_high=1 mid-period -> old 4-cycle period completes, then 1 high / 4 low. Two writes (6/3 then 7/2) before a wrap -> only 7/2 appears.
- Rejected writes: cfg_div=1, cfg_high=0, cfg_high=cfg_div, cfg_ch=7 with NUM_CH=4 -> cfg_err pulses once for each; outputs are unchanged.
- Enable/disable: ch_en[2] deasserted at cnt=1 -> 2 more cycles of period, then constant 0. Re-assert -> outclk high the next cycle with clk_en=1.
- With CLKDIV_PHASE_EN: ch0 phase 0, ch1 phase 2, both P=4 -> ch1 rising edge lags ch0 by exactly 2 cycles in every period.
